// File: rtl/trigger_safety_pkg.sv
// Shared types for the laser trigger safety monitor: FSM state encoding and
// the fault_code values reported to the host.
package trigger_safety_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_LONG  = 2'b01;
  localparam logic [1:0] FC_SHORT = 2'b10;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for bringing an asynchronous level into
// the clk domain; both stages clear to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/trigger_safety_monitor.sv
// Gates a raw laser trigger: enforces a maximum high time and a minimum
// rise-to-rise period (both in clk_div2 ticks) and latches a fault until acked.
module trigger_safety_monitor
  import trigger_safety_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MAX_HIGH   = 1000,
  parameter int MIN_PERIOD = 4000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clk_div2,
  input  logic        trig_in,
  input  logic        fault_clr,
  output logic        laser_en,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] pulse_cnt
);

  localparam logic [CNT_W-1:0] MAX_HIGH_C   = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] MIN_PERIOD_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] high_cnt, high_nxt;
  logic [CNT_W-1:0] per_cnt, per_nxt;
  logic [1:0]       code_nxt;
  logic             pulse_inc;

  logic trig_s, trig_d, div_d;
  logic tick, rise, fall;

  sync_2ff u_trig_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (trig_in),
    .q    (trig_s)
  );

  assign tick = clk_div2 & ~div_d;
  assign rise = trig_s & ~trig_d;
  assign fall = ~trig_s & trig_d;

  // Edge actions are tested before tick so a coinciding tick is dropped.
  always_comb begin
    state_nxt = state;
    high_nxt  = high_cnt;
    per_nxt   = per_cnt;
    code_nxt  = fault_code;
    pulse_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nxt = ST_HIGH;
          high_nxt  = '0;
          per_nxt   = '0;
          pulse_inc = 1'b1;
        end
      end
      ST_HIGH: begin
        if (high_cnt >= MAX_HIGH_C) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_LONG;
        end else if (fall) begin
          state_nxt = ST_LOW;
        end else if (tick) begin
          high_nxt = (high_cnt == CNT_MAX) ? high_cnt : high_cnt + CNT_ONE;
          per_nxt  = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
        end
      end
      ST_LOW: begin
        if (rise) begin
          if (per_cnt < MIN_PERIOD_C) begin
            state_nxt = ST_FAULT;
            code_nxt  = FC_SHORT;
          end else begin
            state_nxt = ST_HIGH;
            high_nxt  = '0;
            per_nxt   = '0;
            pulse_inc = 1'b1;
          end
        end else if (tick) begin
          per_nxt = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
        end
      end
      ST_FAULT: begin
        // An ack while the trigger is still held would re-arm into a live pulse.
        if (fault_clr && !trig_s) begin
          state_nxt = ST_IDLE;
          code_nxt  = FC_NONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        code_nxt  = FC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      high_cnt   <= '0;
      per_cnt    <= '0;
      fault_code <= FC_NONE;
      laser_en   <= 1'b0;
      fault      <= 1'b0;
      pulse_cnt  <= 16'd0;
      trig_d     <= 1'b0;
      div_d      <= 1'b0;
    end else begin
      state      <= state_nxt;
      high_cnt   <= high_nxt;
      per_cnt    <= per_nxt;
      fault_code <= code_nxt;
      laser_en   <= (state_nxt == ST_HIGH);
      fault      <= (state_nxt == ST_FAULT);
      trig_d     <= trig_s;
      div_d      <= clk_div2;
      if (pulse_inc) begin
        pulse_cnt <= pulse_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_trigger_safety_monitor.sv
// Self-checking bench for trigger_safety_monitor: directed scenarios plus
// randomized trigger traffic, compared every cycle against a behavioural model.
module tb_trigger_safety_monitor;

  localparam int CNT_W      = 16;
  localparam int MAX_HIGH   = 8;
  localparam int MIN_PERIOD = 20;
  localparam int SAT        = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_HIGH = 1, M_LOW = 2, M_FAULT = 3;

  // ---------------- clock / reset ----------------
  logic        clk       = 1'b0;
  logic        rstn      = 1'b0;
  logic        clk_div2  = 1'b0;
  logic        trig_in   = 1'b0;
  logic        fault_clr = 1'b0;
  logic        laser_en;
  logic        fault;
  logic [1:0]  fault_code;
  logic [15:0] pulse_cnt;
  logic [1:0]  div_ph = 2'd0;

  always #5 clk = ~clk;

  // clk_div2 as seen by clk: two cycles high, two low -> one tick per 4 clk
  always @(negedge clk) begin
    div_ph   = div_ph + 2'd1;
    clk_div2 = div_ph[1];
  end

  trigger_safety_monitor #(
    .CNT_W      (CNT_W),
    .MAX_HIGH   (MAX_HIGH),
    .MIN_PERIOD (MIN_PERIOD)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_div2   (clk_div2),
    .trig_in    (trig_in),
    .fault_clr  (fault_clr),
    .laser_en   (laser_en),
    .fault      (fault),
    .fault_code (fault_code),
    .pulse_cnt  (pulse_cnt)
  );

  // ---------------- counters / check ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_state, m_hc, m_pc;
  logic [1:0] m_code;
  logic [15:0] m_pcnt;
  logic       m_s1, m_s2, m_s3, m_div_d;
  logic       m_tick, m_rise, m_fall;
  logic [19:0] exp_q[$];

  always @(posedge clk) begin
    if (!rstn) begin
      m_state = M_IDLE; m_hc = 0; m_pc = 0; m_code = 2'b00; m_pcnt = 16'd0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0; m_div_d = 1'b0;
    end else begin
      m_tick = clk_div2 & ~m_div_d;
      m_rise = m_s2 & ~m_s3;
      m_fall = ~m_s2 & m_s3;
      case (m_state)
        M_IDLE:
          if (m_rise) begin
            m_state = M_HIGH; m_hc = 0; m_pc = 0; m_pcnt = m_pcnt + 16'd1;
          end
        M_HIGH:
          if (m_hc >= MAX_HIGH) begin
            m_state = M_FAULT; m_code = 2'b01;
          end else if (m_fall) begin
            m_state = M_LOW;
          end else if (m_tick) begin
            if (m_hc < SAT) m_hc = m_hc + 1;
            if (m_pc < SAT) m_pc = m_pc + 1;
          end
        M_LOW:
          if (m_rise) begin
            if (m_pc < MIN_PERIOD) begin
              m_state = M_FAULT; m_code = 2'b10;
            end else begin
              m_state = M_HIGH; m_hc = 0; m_pc = 0; m_pcnt = m_pcnt + 16'd1;
            end
          end else if (m_tick) begin
            if (m_pc < SAT) m_pc = m_pc + 1;
          end
        default:
          if (fault_clr && !m_s2) begin
            m_state = M_IDLE; m_code = 2'b00;
          end
      endcase
      m_div_d = clk_div2;
      m_s3 = m_s2;
      m_s2 = m_s1;
      m_s1 = trig_in;
    end
    exp_q.push_back({(m_state == M_HIGH), (m_state == M_FAULT), m_code, m_pcnt});
  end

  // ---------------- scoreboard compare ----------------
  logic [19:0] exp_v;
  int las_cnt = 0;
  int las_win = 0;
  bit win = 1'b0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check("outputs", {laser_en, fault, fault_code, pulse_cnt}, exp_v);
    end
    if (laser_en === 1'b1) las_cnt++;
    if (win && laser_en === 1'b1) las_win++;
  end

  // ---------------- drivers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    fault_clr = 1'b1;
    cycles(1);
    fault_clr = 1'b0;
  endtask

  int h, l;

  initial begin
    // reset state
    cycles(3);
    check("rst_laser", laser_en, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_pcnt", pulse_cnt, 0);
    rstn = 1'b1;
    cycles(4);

    // three legal pulses: 5 ticks high, 25 tick period
    las_cnt = 0;
    repeat (3) begin
      trig_in = 1'b1; cycles(20);
      trig_in = 1'b0; cycles(80);
    end
    check("t1_pcnt", pulse_cnt, 3);
    check("t1_laser_cycles", las_cnt, 60);
    check("t1_fault", fault, 0);

    // over-long pulse, ack while held is ignored, ack after release clears
    trig_in = 1'b1; cycles(40);
    pulse_clr();
    cycles(7);
    check("t2_fault", fault, 1);
    check("t2_code", fault_code, 2'b01);
    check("t2_laser", laser_en, 0);
    trig_in = 1'b0; cycles(6);
    check("t2_fault_held", fault, 1);
    pulse_clr();
    cycles(1);
    check("t2_clr_fault", fault, 0);
    check("t2_clr_code", fault_code, 2'b00);

    // second rise 15 ticks after the first
    trig_in = 1'b1; cycles(20);
    trig_in = 1'b0; cycles(40);
    las_win = 0; win = 1'b1;
    trig_in = 1'b1; cycles(20);
    trig_in = 1'b0; cycles(4);
    win = 1'b0;
    check("t3_code", fault_code, 2'b10);
    check("t3_fault", fault, 1);
    check("t3_laser_2nd", las_win, 0);
    check("t3_pcnt", pulse_cnt, 5);
    cycles(4);
    pulse_clr();
    cycles(1);
    check("t3_clr", fault, 0);

    // reset asserted mid-pulse, trigger still high at release
    trig_in = 1'b1; cycles(20);
    check("t4_laser_pre", laser_en, 1);
    #3 rstn = 1'b0;
    #1;
    check("t4_async_laser", laser_en, 0);
    check("t4_async_pcnt", pulse_cnt, 0);
    check("t4_async_code", fault_code, 0);
    cycles(1);
    rstn = 1'b1;
    cycles(6);
    check("t4_laser_after", laser_en, 1);
    check("t4_pcnt_after", pulse_cnt, 1);
    trig_in = 1'b0; cycles(100);

    // pulse counter wrap from 0xFFFF
    #2;
    force dut.pulse_cnt = 16'hFFFF;
    m_pcnt = 16'hFFFF;
    cycles(1);
    #2;
    release dut.pulse_cnt;
    cycles(2);
    check("t5_preload", pulse_cnt, 16'hFFFF);
    trig_in = 1'b1; cycles(20);
    trig_in = 1'b0; cycles(20);
    check("t5_wrap", pulse_cnt, 16'h0000);

    // randomized traffic with sporadic acks
    repeat (20) begin
      h = $urandom_range(1, 48);
      l = $urandom_range(4, 130);
      trig_in = 1'b1;
      repeat (h) begin
        cycles(1);
        fault_clr = (!fault_clr && $urandom_range(0, 15) == 0);
      end
      trig_in = 1'b0;
      repeat (l) begin
        cycles(1);
        fault_clr = (!fault_clr && $urandom_range(0, 11) == 0);
      end
      fault_clr = 1'b0;
    end
    cycles(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trigger_safety_monitor.md
TRIGGER_SAFETY_MONITOR -- requirements
Module: trigger_safety_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of the high-time and period tick counters.
REQ-002 Parameter MAX_HIGH, default 1000: maximum allowed trigger high time, in ticks.
REQ-003 Parameter MIN_PERIOD, default 4000: minimum allowed rise-to-rise period, in ticks.
REQ-004 rstn  input  1  asynchronous active-low reset; the block has one clock, clk.
REQ-005 clk  input  1  system clock; all state is updated on its rising edge.
REQ-006 clk_div2  input  1  divide-by-2 clock from the clock generator, sampled as data in the clk domain.
REQ-007 trig_in  input  1  raw laser trigger request, asynchronous to clk.
REQ-008 fault_clr  input  1  single-cycle fault acknowledge from the host.
REQ-009 laser_en  output  1  gated laser enable, registered.
REQ-010 fault  output  1  latched safety fault, registered.
REQ-011 fault_code  output  2  00 = none, 01 = pulse too long, 10 = period too short; registered.
REQ-012 pulse_cnt  output  16  count of accepted pulses, registered, wraps from 0xFFFF to 0.

Function
REQ-013 tick SHALL be high for one clk cycle when clk_div2 is high and its one-cycle-delayed copy is low, giving 1 tick per 4 clk cycles.
REQ-014 trig_in SHALL pass through a 2-flop synchronizer to give trig_s; rise/fall SHALL be detected against a one-cycle-delayed trig_s.
REQ-015 FSM states: IDLE, HIGH, LOW, FAULT.
REQ-016 IDLE: on rise -> HIGH; high_cnt and per_cnt SHALL be cleared.
REQ-017 HIGH: on tick, high_cnt and per_cnt SHALL each increment, saturating at all-ones.
REQ-018 HIGH: when high_cnt reaches MAX_HIGH (>=) -> FAULT with fault_code 01; this check takes priority over a fall in the same cycle.
REQ-019 HIGH: on fall -> LOW.
REQ-020 LOW: on tick, per_cnt SHALL increment, saturating.
REQ-021 LOW: on rise with per_cnt < MIN_PERIOD -> FAULT with fault_code 10.
REQ-022 LOW: on rise with per_cnt >= MIN_PERIOD -> HIGH; counters SHALL be cleared.
REQ-023 pulse_cnt SHALL increment on every IDLE->HIGH and LOW->HIGH transition.
REQ-024 When a rise/fall and a tick coincide, the edge action wins and that tick is not counted.
REQ-025 laser_en SHALL be 1 iff the registered state is HIGH: asserted 3 clk edges after trig_in rises, deasserted 3 edges after trig_in falls, and deasserted on the same edge that enters FAULT.
REQ-026 fault SHALL be 1 iff the state is FAULT; fault_code SHALL hold its value while in FAULT.
REQ-027 FAULT: fault_clr with trig_s low -> IDLE; fault_code SHALL clear to 00 on the same edge.
REQ-028 FAULT: fault_clr with trig_s high SHALL be ignored; the state stays FAULT.
REQ-029 fault_clr SHALL be ignored in every state other than FAULT.

Reset
REQ-030 While rstn is low: state = IDLE; laser_en = 0, fault = 0, fault_code = 00, pulse_cnt = 0; counters, synchronizer and edge/tick delay flops = 0.
REQ-031 Reset asserted mid-pulse or in FAULT SHALL drop laser_en and fault asynchronously.
REQ-032 After reset release, a trig_in already high SHALL be treated as a rise.

Structure
REQ-033 Package trigger_safety_pkg SHALL hold the FSM state typedef and the fault_code constants FC_NONE, FC_LONG and FC_SHORT.
REQ-034 Sub-module sync_2ff (1-bit, async active-low reset to 0) SHALL implement the trig_in synchronizer.

Verification (MAX_HIGH = 8, MIN_PERIOD = 20)
REQ-035 Pulses of 5 ticks high at a period of 25 ticks, 3 times -> no fault, pulse_cnt = 3, laser_en high 20 clk per pulse.
REQ-036 trig_in held high for 12 ticks -> fault = 1, fault_code = 01, laser_en drops at the 8th tick; fault_clr while trig_in is high is ignored; fault_clr after trig_in falls -> IDLE, fault_code = 00.
REQ-037 Second rise 15 ticks after the first -> fault_code = 10, laser_en never asserts for the second pulse.
REQ-038 rstn pulsed low mid-pulse -> all outputs 0 immediately; trig_in still high at release -> HIGH, pulse_cnt = 1.
REQ-039 pulse_cnt preloaded at 0xFFFF via a forced sequence, then one more valid pulse -> pulse_cnt = 0x0000.
